// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg : shared types, constants and 7-segment encoder | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_LOAD    = 2'd2,
    ST_DONE    = 2'd3
  } seg_state_e;

  localparam int         CONV_CYCLES = 16;
  localparam logic [6:0] SEG_ZERO    = 7'b0000001;
  localparam logic [6:0] SEG_BLANK   = 7'b1111111;

  // Active-low abcdefg, bit6 = a
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = 7'b0000001;
      4'd1:    code = 7'b1001111;
      4'd2:    code = 7'b0010010;
      4'd3:    code = 7'b0000110;
      4'd4:    code = 7'b1001100;
      4'd5:    code = 7'b0100100;
      4'd6:    code = 7'b0100000;
      4'd7:    code = 7'b0001111;
      4'd8:    code = 7'b0000000;
      4'd9:    code = 7'b0000100;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq : shift-per-cycle double-dabble binary to BCD engine | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    shift_en,
  input  logic [15:0]             bin_in,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic [3:0]              ones_next
);

  localparam int BCD_W = 4 * NUM_DIGITS;

  logic [15:0]      r_bin;
  logic [BCD_W-1:0] r_bcd;
  logic [BCD_W-1:0] w_adj;
  logic [BCD_W-1:0] w_shifted;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    assign w_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ? r_bcd[4*g +: 4] + 4'd3
                                                       : r_bcd[4*g +: 4];
  end

  // Carry out of the top nibble cannot occur for products up to 65535
  assign w_shifted = BCD_W'({w_adj, r_bin[15]});
  assign bcd       = r_bcd;
  assign ones_next = w_shifted[3:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin <= '0;
      r_bcd <= '0;
    end else if (load) begin
      r_bin <= bin_in;
      r_bcd <= '0;
    end else if (shift_en) begin
      r_bin <= {r_bin[14:0], 1'b0};
      r_bcd <= w_shifted;
    end
  end

endmodule

`default_nettype wire

// File: rtl/seg_disp_ctrl.sv
// ---------------------------------------------------------------------------
// seg_disp_ctrl : product-to-7seg load sequencer with anode scan | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seg_disp_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 5,
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] product,
  output logic        busy,
  output logic [2:0]  seg_mux_sel,
  output logic        seg_load,
  output logic [6:0]  seg_code,
  output logic        seg_done,
  output logic [2:0]  scan_sel,
  output logic [7:0]  an
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  seg_state_e       r_state;
  logic [4:0]       r_cnt;
  logic [REF_W-1:0] r_ref;
  logic [BCD_W-1:0] w_bcd;
  logic [3:0]       w_ones_nxt;
  logic [3:0]       w_nib_nxt;
  logic [2:0]       w_scan_nxt;
  logic             w_load;
  logic             w_shift;

  assign w_load  = (r_state == ST_IDLE) && start;
  assign w_shift = (r_state == ST_CONVERT);

  bin2bcd_seq #(.NUM_DIGITS(NUM_DIGITS)) u_bin2bcd (
    .clk       (clk),
    .rst       (rst),
    .load      (w_load),
    .shift_en  (w_shift),
    .bin_in    (product),
    .bcd       (w_bcd),
    .ones_next (w_ones_nxt)
  );

  // Nibble for the digit loaded on the next edge while stepping through LOAD
  always_comb begin
    w_nib_nxt = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (r_cnt == 5'(i - 1)) w_nib_nxt = w_bcd[4*i +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      busy        <= 1'b0;
      seg_load    <= 1'b0;
      seg_done    <= 1'b0;
      seg_mux_sel <= '0;
      seg_code    <= SEG_ZERO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_CONVERT;
            r_cnt   <= '0;
            busy    <= 1'b1;
          end
        end
        ST_CONVERT: begin
          // Digit 0 is encoded from the value the final shift produces
          if (r_cnt == 5'(CONV_CYCLES - 1)) begin
            r_state     <= ST_LOAD;
            r_cnt       <= '0;
            seg_load    <= 1'b1;
            seg_mux_sel <= 3'd0;
            seg_code    <= seg_encode(w_ones_nxt);
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        ST_LOAD: begin
          if (r_cnt == 5'(NUM_DIGITS - 1)) begin
            r_state  <= ST_DONE;
            seg_load <= 1'b0;
            seg_done <= 1'b1;
          end else begin
            r_cnt       <= r_cnt + 5'd1;
            seg_mux_sel <= r_cnt[2:0] + 3'd1;
            seg_code    <= seg_encode(w_nib_nxt);
          end
        end
        ST_DONE: begin
          r_state  <= ST_IDLE;
          seg_done <= 1'b0;
          busy     <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_scan_nxt = (scan_sel == 3'(NUM_DIGITS - 1)) ? 3'd0 : scan_sel + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ref    <= '0;
      scan_sel <= '0;
      an       <= 8'hFE;
    end else if (r_ref == REF_W'(REFRESH_DIV - 1)) begin
      r_ref    <= '0;
      scan_sel <= w_scan_nxt;
      an       <= ~(8'd1 << w_scan_nxt);
    end else begin
      r_ref <= r_ref + REF_W'(1);
    end
  end

endmodule

`default_nettype wire
